// File: rtl/if_fetch_queue.sv
// if_fetch_queue: byte-serial instruction fetch with little-endian word assembly feeding a small pc/inst FIFO.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_pc_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        stallfrom_if
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(QUEUE_DEPTH);
  typedef enum logic {IDLE, FETCH} state_t;
  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, word_q, word_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   pc_mem_q [QUEUE_DEPTH];
  logic [31:0]   inst_mem_q [QUEUE_DEPTH];
  logic          push, pop;
  assign if_valid_o   = count_q != '0;
  assign stallfrom_if = !if_valid_o;
  assign if_pc_o      = if_valid_o ? pc_mem_q[rd_ptr_q] : '0;
  assign if_inst_o    = if_valid_o ? inst_mem_q[rd_ptr_q] : '0;
  assign mem_req_o    = state_q == FETCH;
  assign mem_addr_o   = mem_req_o ? fetch_pc_q + {30'd0, byte_cnt_q} : '0;
  // A redirect outranks both a coincident ack and a coincident pop.
  assign pop  = rdy_in && !jump_i && if_valid_o && !stall_i;
  assign push = rdy_in && !jump_i && mem_req_o && mem_ack_i && byte_cnt_q == 2'd3;
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (rdy_in && jump_i) begin
      state_d    = FETCH;
      fetch_pc_d = jump_pc_i & 32'hFFFF_FFFC;
      byte_cnt_d = 2'd0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else if (rdy_in) begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
      if (state_q == IDLE) begin
        state_d = (count_q != FULL || pop) ? FETCH : IDLE;
      end else if (mem_ack_i) begin
        word_d[{byte_cnt_q, 3'b000} +: 8] = mem_data_i;
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (push) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = count_d != FULL ? FETCH : IDLE;
        end
      end
    end
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      byte_cnt_q <= 2'd0;
      word_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        inst_mem_q[wr_ptr_q] <= word_d;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed and randomized stimulus against a stream-level reference model of the fetch queue.
module tb_if_fetch_queue;
  localparam int DEPTH = 2;
  logic        clk_in = 0, rst_in = 0, rdy_in = 1;
  logic        mem_ack_i = 0, stall_i = 1, jump_i = 0;
  logic [7:0]  mem_data_i = 0;
  logic [31:0] jump_pc_i = 0;
  logic        mem_req_o, if_valid_o, stallfrom_if;
  logic [31:0] mem_addr_o, if_pc_o, if_inst_o;
  int          checks = 0, fails = 0, gap = 0;
  bit          gap_mode = 0;
  logic [31:0] m_fpc, m_head;
  int          m_fcnt, m_cnt;
  bit          m_boot, m_pop, m_push;
  logic [31:0] s_addr, s_pc, s_inst;
  logic        s_req, s_valid;

  if_fetch_queue #(.RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .stall_i(stall_i), .jump_i(jump_i), .jump_pc_i(jump_pc_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .stallfrom_if(stallfrom_if)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'd0: return 8'h93;
      32'd1: return 8'h00;
      32'd2: return 8'hA0;
      32'd3: return 8'h00;
      default: begin
        h = a * 32'd2654435761;
        return h[31:24] ^ a[7:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {mem_byte(pc + 3), mem_byte(pc + 2), mem_byte(pc + 1), mem_byte(pc)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
    if (mem_req_o && gap == 0) begin
      mem_ack_i = 1;
      gap = gap_mode ? int'($urandom_range(0, 3)) : 0;
    end else begin
      mem_ack_i = 0;
      if (gap > 0) gap--;
    end
    mem_data_i = mem_byte(mem_addr_o);
  endtask

  // Reference: buffered entries are the pcs m_head, m_head+4, ... (m_cnt of them); fetch address is m_fpc + m_fcnt.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      m_fpc = 0; m_head = 0; m_fcnt = 0; m_cnt = 0; m_boot = 1;
      chk("rst_req", mem_req_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_valid", if_valid_o, 0);
      chk("rst_pc", if_pc_o, 0);
      chk("rst_inst", if_inst_o, 0);
      chk("rst_stallfrom", stallfrom_if, 1);
    end else begin
      chk("m_valid", if_valid_o, m_cnt != 0);
      chk("m_stallfrom", stallfrom_if, m_cnt == 0);
      chk("m_pc", if_pc_o, m_cnt != 0 ? m_head : 32'd0);
      chk("m_inst", if_inst_o, m_cnt != 0 ? mem_word(m_head) : 32'd0);
      if (!m_boot) chk("m_req", mem_req_o, m_cnt < DEPTH);
      if (mem_req_o) chk("m_addr", mem_addr_o, m_fpc + 32'(m_fcnt));
      if (rdy_in) begin
        m_boot = 0;
        if (jump_i) begin
          m_fpc = jump_pc_i & ~32'd3; m_head = m_fpc; m_fcnt = 0; m_cnt = 0;
        end else begin
          m_pop = m_cnt > 0 && !stall_i;
          m_push = 0;
          if (mem_ack_i) begin
            m_fcnt++;
            if (m_fcnt == 4) begin
              m_fcnt = 0; m_fpc += 4; m_push = 1;
            end
          end
          if (m_pop) m_head += 4;
          m_cnt += int'(m_push) - int'(m_pop);
        end
      end
    end
  end

  initial begin
    repeat (3) tick;
    chk("reset_req", mem_req_o, 0);
    chk("reset_valid", if_valid_o, 0);
    chk("reset_stallfrom", stallfrom_if, 1);
    rst_in = 1;
    chk("release_req", mem_req_o, 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("first_addr", mem_addr_o, i);
      tick;
    end
    chk("first_valid", if_valid_o, 1);
    chk("first_pc", if_pc_o, 0);
    chk("first_inst", if_inst_o, 32'h00A00093);
    repeat (4) tick;
    chk("full_req", mem_req_o, 0);
    chk("full_pc", if_pc_o, 0);
    tick;
    chk("full_hold_req", mem_req_o, 0);
    stall_i = 0;
    tick;
    chk("pop1_pc", if_pc_o, 4);
    chk("resume_req", mem_req_o, 1);
    chk("resume_addr", mem_addr_o, 8);
    tick;
    chk("pop2_valid", if_valid_o, 0);
    stall_i = 1;
    jump_i = 1; jump_pc_i = 32'h10;
    tick;
    jump_i = 0;
    chk("j10_addr", mem_addr_o, 32'h10);
    repeat (2) tick;
    chk("j10_byte2", mem_addr_o, 32'h12);
    jump_i = 1; jump_pc_i = 32'h1006;
    tick;
    jump_i = 0;
    chk("jump_valid", if_valid_o, 0);
    chk("jump_req", mem_req_o, 1);
    chk("jump_addr", mem_addr_o, 32'h1004);
    repeat (3) tick;
    chk("b3_addr", mem_addr_o, 32'h1007);
    jump_i = 1; jump_pc_i = 32'h2000;
    tick;
    jump_i = 0;
    chk("b3jump_valid", if_valid_o, 0);
    chk("b3jump_addr", mem_addr_o, 32'h2000);
    repeat (2) tick;
    chk("rdy_pre_addr", mem_addr_o, 32'h2002);
    {s_req, s_addr, s_valid, s_pc, s_inst} = {mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o};
    rdy_in = 0; stall_i = 0;
    for (int k = 0; k < 5; k++) begin
      jump_i = k == 2; jump_pc_i = 32'h3000;
      tick;
      chk("frz_req", mem_req_o, s_req);
      chk("frz_addr", mem_addr_o, s_addr);
      chk("frz_valid", if_valid_o, s_valid);
      chk("frz_pc", if_pc_o, s_pc);
      chk("frz_inst", if_inst_o, s_inst);
    end
    jump_i = 0; rdy_in = 1;
    for (int k = 0; k < 20 && !if_valid_o; k++) tick;
    chk("resume_valid", if_valid_o, 1);
    chk("resume_pc", if_pc_o, 32'h2000);
    chk("resume_inst", if_inst_o, mem_word(32'h2000));
    gap_mode = 1;
    jump_i = 1; jump_pc_i = 32'h40;
    tick;
    jump_i = 0;
    repeat (80) tick;
    jump_i = 1; jump_pc_i = 32'hFFFF_FFF8;
    tick;
    jump_i = 0;
    repeat (60) tick;
    for (int n = 0; n < 3000; n++) begin
      gap_mode = $urandom_range(0, 1) == 1;
      stall_i = $urandom_range(0, 9) < 3;
      rdy_in = $urandom_range(0, 9) != 0;
      jump_i = $urandom_range(0, 49) == 0;
      jump_pc_i = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
      tick;
    end
    rdy_in = 1; jump_i = 0; stall_i = 1; gap_mode = 0;
    @(posedge clk_in);
    #3 rst_in = 0;
    repeat (2) tick;
    rst_in = 1;
    chk("rerst_req", mem_req_o, 0);
    chk("rerst_valid", if_valid_o, 0);
    tick;
    chk("rerst_req1", mem_req_o, 1);
    chk("rerst_addr", mem_addr_o, 0);
    stall_i = 0;
    repeat (40) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
